fp_norm_round: RTL and testbench

- Stage directly downstream of the FP32 add/sub datapath.
- Takes the raw 28-bit sum mantissa, biased exponent, sign, effective-operation bit and sticky-loss bit.
- Normalises by iterative left shift, rounds to nearest-even and packs an IEEE-754 single.
- Multi-cycle FSM with valid/ready handshakes on both sides.

---
 rtl/fp_norm_round.sv | 134 +++++++++++++
 tb/tb_fp_norm_round.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fp_norm_round.sv
// fp_norm_round: iterative normalise, round-to-nearest-even and FP32 pack after the adder; `define FP_FLAGS_EN adds out_flags
module fp_norm_round #(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic        in_operator,
    input  logic [7:0]  in_exp,
    input  logic [27:0] in_mantis,
    input  logic        in_loss,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
`ifdef FP_FLAGS_EN
    ,
    output logic [3:0]  out_flags
`endif
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;
    state_t      state_q, state_d;
    logic        sign_q, sign_d, op_q, op_d, loss_q, loss_d, valid_q, valid_d;
    logic [7:0]  exp_q, exp_d, sh, exp_field;
    logic [27:0] mant_q, mant_d;
    logic [31:0] data_q, data_d, res;
    logic [30:0] sum;
    logic [4:0]  lz;
    logic        found, g, s, ru, ovf;
`ifdef FP_FLAGS_EN
    logic [3:0]  flags_q, flags_d;
    assign out_flags = flags_q;
`endif
    assign in_ready  = state_q == IDLE;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    // leading zeros of the working mantissa, used to cap each shift step
    always_comb begin
        lz    = 5'd0;
        found = 1'b0;
        for (int i = 27; i >= 0; i--) begin
            found = found | mant_q[i];
            lz    = lz + {4'd0, ~found};
        end
    end
    // shift this cycle = min(SHIFT_STEP, leading zeros, exp-1); exp-1 stops at the subnormal boundary
    always_comb begin
        sh = 8'(SHIFT_STEP);
        sh = ({3'd0, lz} < sh) ? {3'd0, lz} : sh;
        sh = (exp_q - 8'd1 < sh) ? exp_q - 8'd1 : sh;
    end
    // RNE on guard/sticky; the 31-bit add carries subnormal->normal and max-normal->infinity
    always_comb begin
        g         = mant_q[3];
        s         = |mant_q[2:0] | loss_q;
        ru        = g & (s | mant_q[4]);
        exp_field = mant_q[27] ? exp_q : 8'd0;
        sum       = {exp_field, mant_q[26:4]} + {30'd0, ru};
        ovf       = (exp_q == 8'hFF) || (sum[30:23] == 8'hFF);
        res       = ovf ? {sign_q, 8'hFF, 23'd0}
                  : {(mant_q == 28'd0 && !loss_q && op_q) ? 1'b0 : sign_q, sum};
    end
    // next-state and datapath updates for the IDLE/NORM/ROUND/OUT sequence
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        op_d    = op_q;
        loss_d  = loss_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        valid_d = valid_q;
        data_d  = data_q;
`ifdef FP_FLAGS_EN
        flags_d = flags_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = NORM;
                sign_d  = in_sign;
                op_d    = in_operator;
                loss_d  = in_loss;
                exp_d   = in_exp;
                mant_d  = in_mantis;
            end
            NORM: if (exp_q == 8'hFF || mant_q == 28'd0 || mant_q[27] || exp_q <= 8'd1)
                state_d = ROUND;
            else begin
                mant_d = mant_q << sh;
                exp_d  = exp_q - sh;
            end
            ROUND: begin
                state_d = OUT;
                valid_d = 1'b1;
                data_d  = res;
`ifdef FP_FLAGS_EN
                flags_d = {g | s, ovf, !ovf && sum[30:23] == 8'd0 && (g | s), !ovf && sum == 31'd0};
`endif
            end
            OUT: if (out_ready) begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end
    // state and registered outputs, async active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            op_q    <= 1'b0;
            loss_q  <= 1'b0;
            exp_q   <= 8'd0;
            mant_q  <= 28'd0;
            valid_q <= 1'b0;
            data_q  <= 32'd0;
`ifdef FP_FLAGS_EN
            flags_q <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            op_q    <= op_d;
            loss_q  <= loss_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            valid_q <= valid_d;
            data_q  <= data_d;
`ifdef FP_FLAGS_EN
            flags_q <= flags_d;
`endif
        end
    end
endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: random and directed checks of fp_norm_round at SHIFT_STEP 1 and 4 against an arithmetic model
module tb_fp_norm_round;
    localparam int STEP_A = 1;
    localparam int STEP_B = 4;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_sign, in_operator, in_loss, out_ready;
    logic [7:0]  in_exp;
    logic [27:0] in_mantis;
    logic        rdy_a, rdy_b, vld_a, vld_b;
    logic [31:0] data_a, data_b;
    logic [3:0]  flags_a, flags_b;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    fp_norm_round #(.SHIFT_STEP(STEP_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .in_sign(in_sign), .in_operator(in_operator), .in_exp(in_exp),
        .in_mantis(in_mantis), .in_loss(in_loss), .out_valid(vld_a),
        .out_ready(out_ready), .out_data(data_a)
`ifdef FP_FLAGS_EN
        , .out_flags(flags_a)
`endif
    );
    fp_norm_round #(.SHIFT_STEP(STEP_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .in_sign(in_sign), .in_operator(in_operator), .in_exp(in_exp),
        .in_mantis(in_mantis), .in_loss(in_loss), .out_valid(vld_b),
        .out_ready(out_ready), .out_data(data_b)
`ifdef FP_FLAGS_EN
        , .out_flags(flags_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // value-level reference: normalise by the total shift, then round the dropped nibble against one half
    function automatic void model(input logic [7:0] e, input logic [27:0] m, input logic sg, input logic op,
                                  input logic ls, output logic [31:0] d, output logic [3:0] f, output int shifts);
        int          lz, ei, rem;
        logic [27:0] mm;
        longint      kept, expf, mag;
        logic        inex, ovf, up;
        ei = int'(e);
        lz = 28;
        for (int i = 0; i < 28; i++) if (m[i]) lz = 27 - i;
        shifts = (e == 8'hFF || m == 28'd0 || ei <= 1) ? 0 : (lz < ei - 1 ? lz : ei - 1);
        mm   = m << shifts;
        rem  = int'(mm % 28'd16);
        kept = longint'(mm / 28'd16);
        expf = mm[27] ? longint'(ei - shifts) : 0;
        inex = rem != 0 || ls;
        up   = rem > 8 || (rem == 8 && (ls || kept % 2 == 1));
        mag  = expf * 64'd8388608 + kept % 64'd8388608 + longint'(up);
        ovf  = e == 8'hFF || mag >= 64'h7F800000;
        d    = ovf ? {sg, 8'hFF, 23'd0} : (m == 28'd0 && !ls) ? {sg & ~op, 31'd0} : {sg, 31'(mag)};
        f    = {inex, ovf, !ovf && d[30:23] == 8'd0 && inex, !ovf && d[30:0] == 31'd0};
    endfunction

    task automatic run_op(input logic [7:0] e, input logic [27:0] m, input logic sg, input logic op, input logic ls);
        logic [31:0] ed, da, db;
        logic [3:0]  ef, fa, fb;
        int          sh, lat_a, lat_b;
        model(e, m, sg, op, ls, ed, ef, sh);
        da = '0; db = '0; fa = '0; fb = '0; lat_a = 0; lat_b = 0;
        @(negedge clk);
        check("in_ready_idle", 32'(rdy_a & rdy_b), 32'd1);
        in_exp = e; in_mantis = m; in_sign = sg; in_operator = op; in_loss = ls; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 1; c <= 120 && (lat_a == 0 || lat_b == 0); c++) begin
            @(posedge clk);
            #1;
            if (vld_a && lat_a == 0) begin lat_a = c; da = data_a; fa = flags_a; end
            if (vld_b && lat_b == 0) begin lat_b = c; db = data_b; fb = flags_b; end
        end
        check($sformatf("data_s1 e=%h m=%h", e, m), da, ed);
        check($sformatf("data_s4 e=%h m=%h", e, m), db, ed);
        check($sformatf("lat_s1 e=%h m=%h", e, m), 32'(lat_a), 32'(2 + (sh + STEP_A - 1) / STEP_A));
        check($sformatf("lat_s4 e=%h m=%h", e, m), 32'(lat_b), 32'(2 + (sh + STEP_B - 1) / STEP_B));
`ifdef FP_FLAGS_EN
        check($sformatf("flags_s1 e=%h m=%h", e, m), 32'(fa), 32'(ef));
        check($sformatf("flags_s4 e=%h m=%h", e, m), 32'(fb), 32'(ef));
`endif
        @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_exp = '0; in_mantis = '0; in_sign = 1'b0; in_operator = 1'b0; in_loss = 1'b0;
        #1;
        check("rst_in_ready", 32'(rdy_a & rdy_b), 32'd1);
        check("rst_out_valid", 32'(vld_a | vld_b), 32'd0);
        check("rst_out_data", data_a | data_b, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // directed cases
        run_op(8'h80, 28'h8000000, 1'b0, 1'b0, 1'b0);
        run_op(8'h7F, 28'h0000010, 1'b0, 1'b0, 1'b0);
        run_op(8'h7F, 28'h8000008, 1'b0, 1'b0, 1'b0);
        run_op(8'h7F, 28'h8000018, 1'b0, 1'b0, 1'b0);
        run_op(8'h7F, 28'h8000008, 1'b0, 1'b0, 1'b1);
        run_op(8'hFE, 28'hFFFFFF8, 1'b0, 1'b0, 1'b0);
        run_op(8'hFF, 28'h1234567, 1'b1, 1'b0, 1'b0);
        run_op(8'h85, 28'h0000000, 1'b1, 1'b1, 1'b0);
        run_op(8'h90, 28'h0000000, 1'b1, 1'b0, 1'b1);
        run_op(8'h01, 28'h0400000, 1'b0, 1'b0, 1'b0);
        run_op(8'h03, 28'h0000100, 1'b0, 1'b0, 1'b0);
        run_op(8'h01, 28'h7FFFFF8, 1'b0, 1'b0, 1'b0);
        run_op(8'h01, 28'h0000008, 1'b1, 1'b0, 1'b0);
        // backpressure: result must stay put while out_ready is low
        @(negedge clk);
        out_ready = 1'b0;
        in_exp = 8'h80; in_mantis = 28'h8000000; in_sign = 1'b0; in_operator = 1'b0; in_loss = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 0; c < 20 && !vld_a; c++) begin
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 10; c++) begin
            check("hold_valid", 32'(vld_a & vld_b), 32'd1);
            check("hold_data", data_a, 32'h40000000);
            check("hold_in_ready", 32'(rdy_a | rdy_b), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", 32'(vld_a | vld_b), 32'd0);
        check("release_in_ready", 32'(rdy_a & rdy_b), 32'd1);
        // reset mid-NORM abandons the operand
        @(negedge clk);
        in_exp = 8'h7F; in_mantis = 28'h0000010; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(vld_a | vld_b), 32'd0);
        check("midrst_in_ready", 32'(rdy_a & rdy_b), 32'd1);
        check("midrst_out_data", data_a | data_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h7F, 28'h8000018, 1'b1, 1'b0, 1'b0);
        // randomized operands biased toward the boundary exponents
        for (int n = 0; n < 300; n++) begin
            logic [7:0]  e;
            logic [27:0] m;
            int          r;
            r = int'($urandom_range(0, 9));
            e = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : (r == 2) ? 8'h01 :
                (r == 3) ? 8'($urandom_range(2, 30)) : 8'($urandom_range(0, 254));
            m = 28'($urandom) >> $urandom_range(0, 28);
            run_op(e, m, 1'($urandom), 1'($urandom), 1'($urandom));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
